// File: rtl/alu_req_scheduler_if.sv
// Bundle of request, shared-ALU and response signals for the ALU request scheduler.
// The slave modport is the scheduler's view; master is the requester/ALU/consumer side.
interface alu_req_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*4-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [1:0]            alu_fun;
    logic                  arith_en;
    logic                  logic_en;
    logic                  cmp_en;
    logic                  shift_en;
    logic [WIDTH-1:0]      alu_out;
    logic                  alu_flag;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;
    logic                  busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en,
        input  alu_out, alu_flag,
        output resp_valid, resp_id, resp_data, resp_err, busy,
        input  resp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en,
        output alu_out, alu_flag,
        input  resp_valid, resp_id, resp_data, resp_err, busy,
        output resp_ready
    );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one four-unit ALU between NREQ requesters;
// one operation in flight, result returned with the requester index.
module alu_req_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    alu_req_scheduler_if.slave    bus
);

    localparam int OPW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  grant_r;
    logic [1:0]       fun_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       en_r;
    logic [NREQ-1:0]  req_ready_r;
    logic             resp_valid_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             resp_err_r;
    logic             busy_r;

    logic [NREQ-1:0]  hi_s;
    logic             grant_any_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic [OPW-1:0]   sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [ID_W-1:0]  next_ptr_s;
    logic             resp_hs_s;

    // Lowest set index of a request vector.
    function automatic logic [ID_W-1:0] first_set(input logic [NREQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = v[i] ? ID_W'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

    // Unit select: bit0 arith, bit1 logic, bit2 cmp, bit3 shift.
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            2'b00:   oh = 4'b0001;
            2'b01:   oh = 4'b0010;
            2'b10:   oh = 4'b0100;
            2'b11:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Round-robin grant: prefer requesters at or above rr_ptr, then wrap to the lowest.
    always_comb begin
        hi_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_s[i] = bus.req_valid[i] & (ID_W'(i) >= rr_ptr_r);
        end
        grant_any_s = |bus.req_valid;
        grant_idx_s = (|hi_s) ? first_set(hi_s) : first_set(bus.req_valid);
    end

    // Operand and op mux for the granted requester.
    always_comb begin
        sel_op_s = '0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_op_s = (grant_idx_s == ID_W'(i)) ? bus.req_op[i*OPW +: OPW]   : sel_op_s;
            sel_a_s  = (grant_idx_s == ID_W'(i)) ? bus.req_a[i*WIDTH +: WIDTH] : sel_a_s;
            sel_b_s  = (grant_idx_s == ID_W'(i)) ? bus.req_b[i*WIDTH +: WIDTH] : sel_b_s;
        end
    end

    // Pointer advance past the served requester and response handshake detect.
    always_comb begin
        next_ptr_s = (grant_r == ID_W'(NREQ - 1)) ? '0 : grant_r + ID_W'(1'b1);
        resp_hs_s  = resp_valid_r & bus.resp_ready;
    end

    // Scheduler FSM; every output is a flop loaded here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            grant_r      <= '0;
            fun_r        <= 2'b00;
            a_r          <= '0;
            b_r          <= '0;
            en_r         <= 4'b0000;
            req_ready_r  <= '0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        grant_r     <= grant_idx_s;
                        fun_r       <= sel_op_s[1:0];
                        a_r         <= sel_a_s;
                        b_r         <= sel_b_s;
                        en_r        <= unit_onehot(sel_op_s[3:2]);
                        req_ready_r <= id_to_onehot(grant_idx_s);
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        en_r        <= 4'b0000;
                        req_ready_r <= '0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // The unit samples its enable this cycle and answers in WAIT.
                    en_r        <= 4'b0000;
                    req_ready_r <= '0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    resp_data_r  <= bus.alu_out;
                    resp_err_r   <= ~bus.alu_flag;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_hs_s) begin
                        resp_valid_r <= 1'b0;
                        rr_ptr_r     <= next_ptr_s;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_RESP;
                    end
                end
                default: begin
                    en_r         <= 4'b0000;
                    req_ready_r  <= '0;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.alu_a      = a_r;
    assign bus.alu_b      = b_r;
    assign bus.alu_fun    = fun_r;
    assign bus.arith_en   = en_r[0];
    assign bus.logic_en   = en_r[1];
    assign bus.cmp_en     = en_r[2];
    assign bus.shift_en   = en_r[3];
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = grant_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler with a behavioural four-unit ALU model.
module tb_alu_req_scheduler;

    logic CLK;
    logic RST;

    alu_req_scheduler_if #(.WIDTH(16), .NREQ(4), .ID_W(2)) bus ();

    alu_req_scheduler #(.WIDTH(16), .NREQ(4), .ID_W(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } item_t;

    item_t       grant_q[$];
    item_t       resp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [3:0]  rv = 4'b0000;
    logic [3:0]  op_v[4];
    logic [15:0] a_v[4];
    logic [15:0] b_v[4];
    logic        prev_valid = 1'b0;
    logic        saw_rr2 = 1'b0;
    logic        drop_flag = 1'b0;
    logic [62:0] snap;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op[3:2])
            2'b00: case (op[1:0])
                2'b00: r = a + b;   2'b01: r = a - b;   2'b10: r = a + 16'h1; default: r = a - 16'h1;
            endcase
            2'b01: case (op[1:0])
                2'b00: r = a & b;   2'b01: r = a | b;   2'b10: r = a ^ b;     default: r = ~a;
            endcase
            2'b10: case (op[1:0])
                2'b00: r = {15'b0, a == b}; 2'b01: r = {15'b0, a < b};
                2'b10: r = {15'b0, a > b};  default: r = {15'b0, a != b};
            endcase
            default: case (op[1:0])
                2'b00: r = a << b[3:0]; 2'b01: r = a >> b[3:0];
                2'b10: r = a << 1;      default: r = {a[14:0], a[15]};
            endcase
        endcase
        return r;
    endfunction

    function automatic logic [1:0] en_to_unit(input logic [3:0] en);
        case (en)
            4'b0010: return 2'b01;
            4'b0100: return 2'b10;
            4'b1000: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    logic [3:0] en_m;
    assign en_m = {bus.shift_en, bus.cmp_en, bus.logic_en, bus.arith_en};

    // ALU units: registered result and flag one cycle after an enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.alu_out  <= 16'h0;
            bus.alu_flag <= 1'b0;
        end else if (en_m != 4'b0000 && !(drop_flag && bus.cmp_en)) begin
            bus.alu_out  <= alu_ref({en_to_unit(en_m), bus.alu_fun}, bus.alu_a, bus.alu_b);
            bus.alu_flag <= 1'b1;
        end else begin
            bus.alu_out  <= 16'h0;
            bus.alu_flag <= 1'b0;
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            bus.req_op[i*4 +: 4]   = op_v[i];
            bus.req_a[i*16 +: 16]  = a_v[i];
            bus.req_b[i*16 +: 16]  = b_v[i];
        end
        bus.req_valid = rv;
    endtask

    task automatic expect_req(input int id, input logic [15:0] data, input logic err);
        item_t it;
        it.id = 2'(id); it.op = op_v[id]; it.a = a_v[id]; it.b = b_v[id];
        it.data = data; it.err = err; it.cyc = 0;
        grant_q.push_back(it);
    endtask

    function automatic logic [62:0] all_outs();
        return {bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_fun, en_m, bus.resp_valid,
                bus.resp_id, bus.resp_data, bus.resp_err, bus.busy};
    endfunction

    // One clock: sample #1 after the edge, score grants and responses, update requesters.
    task automatic tick();
        item_t it;
        @(posedge CLK);
        #1;
        cyc++;
        if (bus.req_ready[2]) saw_rr2 = 1'b1;
        if (bus.req_ready != 4'b0000) begin
            if (grant_q.size() == 0) begin
                chk_eq("grant_unexp", bus.req_ready, 64'h0);
            end else begin
                it = grant_q.pop_front();
                chk_eq("grant_id", bus.req_ready, 64'h1 << it.id);
                chk_eq("issue_en", en_m, 64'h1 << it.op[3:2]);
                chk_eq("issue_fun", bus.alu_fun, it.op[1:0]);
                chk_eq("issue_ab", {bus.alu_a, bus.alu_b}, {it.a, it.b});
                chk_eq("issue_busy", bus.busy, 64'h1);
                it.cyc = cyc;
                resp_q.push_back(it);
                if (grant_q.size() == 0) begin
                    rv = 4'b0000;
                    apply();
                end
            end
        end else if (en_m != 4'b0000) begin
            chk_eq("en_stray", en_m, 64'h0);
        end
        if (bus.resp_valid && !prev_valid) begin
            if (resp_q.size() == 0) begin
                chk_eq("resp_unexp", bus.resp_valid, 64'h0);
            end else begin
                it = resp_q.pop_front();
                chk_eq("resp_latency", cyc - it.cyc, 64'd2);
                chk_eq("resp_id", bus.resp_id, it.id);
                chk_eq("resp_data", bus.resp_data, it.data);
                chk_eq("resp_err", bus.resp_err, it.err);
            end
        end
        prev_valid = bus.resp_valid;
    endtask

    task automatic run_until_idle(input int max);
        for (int k = 0; k < max; k++) begin
            if (grant_q.size() == 0 && resp_q.size() == 0 && !bus.resp_valid && !bus.busy) break;
            tick();
        end
        chk_eq("drain", {grant_q.size() != 0, resp_q.size() != 0, bus.busy}, 64'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        prev_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_v[i] = 4'b0000; a_v[i] = 16'h0; b_v[i] = 16'h0;
        end
        apply();

        // Reset state
        do_reset();
        chk_eq("rst_outs", all_outs(), 64'h0);
        tick();
        chk_eq("rst_idle_busy", bus.busy, 64'h0);

        // Single AND from requester 1
        op_v[1] = 4'b0100; a_v[1] = 16'hF0F0; b_v[1] = 16'h0FF0;
        expect_req(1, 16'h00F0, 1'b0);
        rv = 4'b0010; apply();
        run_until_idle(20);

        // Round robin from a fresh pointer: 0,1,2,3,0 with OR
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op_v[i] = 4'b0101;
            a_v[i]  = 16'h0101 << i;
            b_v[i]  = 16'h8000 >> (i * 3);
        end
        for (int n = 0; n < 5; n++) begin
            expect_req(n % 4, a_v[n % 4] | b_v[n % 4], 1'b0);
        end
        rv = 4'b1111; apply();
        run_until_idle(60);

        // Backpressure on requester 3 (pointer now 1), requester 0 waits behind it
        op_v[3] = 4'b0000; a_v[3] = 16'h1234; b_v[3] = 16'h1111;
        expect_req(3, 16'h2345, 1'b0);
        bus.resp_ready = 1'b0;
        rv = 4'b1000; apply();
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_valid) break;
            tick();
        end
        chk_eq("bp_valid", bus.resp_valid, 64'h1);
        snap = {bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err, 43'h0};
        op_v[0] = 4'b0110; a_v[0] = 16'h00FF; b_v[0] = 16'h0F0F;
        expect_req(0, 16'h0FF0, 1'b0);
        rv = 4'b0001; apply();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_eq("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_err, 43'h0}, snap);
            chk_eq("bp_no_ready", bus.req_ready, 64'h0);
        end
        bus.resp_ready = 1'b1;
        tick();
        chk_eq("bp_release", {bus.resp_valid, bus.busy, bus.req_ready}, 64'h0);
        tick();
        chk_eq("bp_regrant", bus.req_ready, 64'h1);
        run_until_idle(20);

        // Compare unit that never raises its flag
        drop_flag = 1'b1;
        op_v[1] = 4'b1000; a_v[1] = 16'h0005; b_v[1] = 16'h0005;
        expect_req(1, 16'h0000, 1'b1);
        rv = 4'b0010; apply();
        run_until_idle(20);
        drop_flag = 1'b0;

        // Reset while requester 2's shift sits in WAIT
        op_v[2] = 4'b1100; a_v[2] = 16'h0003; b_v[2] = 16'h0004;
        expect_req(2, 16'h0030, 1'b0);
        rv = 4'b0100; apply();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.req_ready != 4'b0000) break;
        end
        tick();
        chk_eq("wait_busy", bus.busy, 64'h1);
        RST = 1'b1;
        tick();
        chk_eq("rst_mid_outs", all_outs(), 64'h0);
        RST = 1'b0;
        resp_q.delete();
        grant_q.delete();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_eq("rst_no_resp", bus.resp_valid, 64'h0);
        end
        op_v[0] = 4'b0001; a_v[0] = 16'h0100; b_v[0] = 16'h0001;
        op_v[3] = 4'b0101; a_v[3] = 16'h0F00; b_v[3] = 16'h000F;
        expect_req(0, 16'h00FF, 1'b0);
        rv = 4'b1101; apply();
        run_until_idle(20);

        // Requester 2 withdraws as requester 0 is granted
        do_reset();
        saw_rr2 = 1'b0;
        op_v[0] = 4'b0111; a_v[0] = 16'h00FF; b_v[0] = 16'h1234;
        op_v[2] = 4'b0000; a_v[2] = 16'h0001; b_v[2] = 16'h0001;
        expect_req(0, 16'hFF00, 1'b0);
        rv = 4'b0101; apply();
        run_until_idle(20);
        for (int k = 0; k < 4; k++) tick();
        chk_eq("wd_no_ready2", saw_rr2, 64'h0);
        chk_eq("wd_idle", bus.busy, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
